// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer.
// State encoding is visible to the bench for readable checks.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register.
// Loads a value or increments, wrapping at PROG_SIZE.
module pc_reg
    import fetch_seq_pkg::*;
#(
    parameter int PROG_SIZE = 32,
    localparam int AW = $clog2(PROG_SIZE)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_value,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    localparam logic [AW-1:0] LAST = AW'(PROG_SIZE - 1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= (pc == LAST) ? '0 : pc + AW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: IDLE -> FETCH -> EXEC -> FETCH/HALT.
// Outputs decode from registered state; only ir_load sees imem_ack.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PROG_SIZE = 32,
    localparam int AW = $clog2(PROG_SIZE)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    output logic          ir_load,
    output logic          exec_en,
    input  logic          exec_done,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          halt_req,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          addr_err
);

    state_t state;
    logic   fire;
    logic   oor;

    assign fire = (state == ST_EXEC) && exec_done;
    // Only reachable when PROG_SIZE is not a power of two.
    assign oor  = branch_taken && (int'(branch_target) >= PROG_SIZE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            addr_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        state <= halt_req ? ST_HALT : ST_FETCH;
                        if (oor) addr_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    pc_reg #(
        .PROG_SIZE (PROG_SIZE)
    ) u_pc (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load       (fire && branch_taken),
        .load_value (oor ? '0 : branch_target),
        .inc        (fire && !branch_taken),
        .pc         (pc)
    );

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign ir_load   = (state == ST_FETCH) && imem_ack;
    assign exec_en   = (state == ST_EXEC);
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PROG_SIZE=32 and PROG_SIZE=20 side by side,
// both driven by the same stimulus and compared with a reference model.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       start, ack, done, taken, halt;
    logic [4:0] tgt;

    logic       req     [2];
    logic [4:0] addr    [2];
    logic       ild     [2];
    logic       exe     [2];
    logic [4:0] pcv     [2];
    logic       hlt     [2];
    logic       err     [2];

    int         total = 0;
    int         bad   = 0;
    int         cycles = 0;
    int         ild_cnt = 0;
    int         req_cnt = 0;
    int         c0;

    state_t     mst [2];
    int         mpc [2];
    bit         merr[2];
    int         psz [2] = '{32, 20};

    always #5 sys_clk = ~sys_clk;

    fetch_sequencer #(.PROG_SIZE(32)) dut32 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack),
        .ir_load(ild[0]), .exec_en(exe[0]), .exec_done(done),
        .branch_taken(taken), .branch_target(tgt), .halt_req(halt),
        .pc(pcv[0]), .halted(hlt[0]), .addr_err(err[0])
    );

    fetch_sequencer #(.PROG_SIZE(20)) dut20 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack),
        .ir_load(ild[1]), .exec_en(exe[1]), .exec_done(done),
        .branch_taken(taken), .branch_target(tgt), .halt_req(halt),
        .pc(pcv[1]), .halted(hlt[1]), .addr_err(err[1])
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mst[i]  = ST_IDLE;
            mpc[i]  = 0;
            merr[i] = 1'b0;
        end
    endtask

    // Reference: next pc is target, 0 for out-of-range, else (pc+1) mod size.
    task automatic model_step();
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (mst[i])
                ST_IDLE, ST_HALT: if (start) mst[i] = ST_FETCH;
                ST_FETCH: if (ack) mst[i] = ST_EXEC;
                default: if (done) begin
                    if (taken) begin
                        if (int'({27'b0, tgt}) >= psz[i]) begin
                            mpc[i]  = 0;
                            merr[i] = 1'b1;
                        end else begin
                            mpc[i] = int'({27'b0, tgt});
                        end
                    end else begin
                        mpc[i] = (mpc[i] + 1) % psz[i];
                    end
                    mst[i] = halt ? ST_HALT : ST_FETCH;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("req%0d", i), 32'(req[i]), 32'(mst[i] == ST_FETCH));
            chk($sformatf("addr%0d", i), 32'(addr[i]), mpc[i]);
            chk($sformatf("ir_load%0d", i), 32'(ild[i]),
                32'(mst[i] == ST_FETCH && ack));
            chk($sformatf("exec_en%0d", i), 32'(exe[i]), 32'(mst[i] == ST_EXEC));
            chk($sformatf("pc%0d", i), 32'(pcv[i]), mpc[i]);
            chk($sformatf("halted%0d", i), 32'(hlt[i]), 32'(mst[i] == ST_HALT));
            chk($sformatf("addr_err%0d", i), 32'(err[i]), 32'(merr[i]));
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
        check_all();
        if (ild[0]) ild_cnt++;
        if (req[0]) req_cnt++;
        model_step();
        cycles++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_instr(int aw, int dw, bit tk, int tg, bit hl);
        ack = 1'b0;
        repeat (aw) cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        repeat (dw) cyc();
        done  = 1'b1;
        taken = tk;
        tgt   = 5'(tg);
        halt  = hl;
        cyc();
        done  = 1'b0;
        taken = 1'b0;
        halt  = 1'b0;
        tgt   = 5'($urandom);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        {start, ack, done, taken, halt} = '0;
        tgt = '0;
        model_reset();
        @(posedge sys_clk);
        #1;
        cyc();
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        cyc();

        // linear run, ack and done one cycle late
        start = 1'b1;
        cyc();
        start = 1'b0;
        c0 = cycles;
        ild_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            chk("lin_pc", 32'(pcv[0]), k);
            run_instr(1, 1, 1'b0, 0, 1'b0);
        end
        chk("lin_cycles", cycles - c0, 16);
        chk("lin_ir_loads", ild_cnt, 4);

        // wait states at address 5
        run_instr(0, 0, 1'b0, 0, 1'b0);
        chk("ws_addr", 32'(addr[0]), 5);
        req_cnt = 0;
        ild_cnt = 0;
        run_instr(3, 0, 1'b0, 0, 1'b0);
        chk("ws_req_cycles", req_cnt, 4);
        chk("ws_ir_loads", ild_cnt, 1);

        // branch and halt together
        run_instr(0, 0, 1'b1, 17, 1'b1);
        chk("bh_pc", 32'(pcv[0]), 17);
        chk("bh_halted", 32'(hlt[0]), 1);
        chk("bh_req", 32'(req[0]), 0);
        ack = 1'b1;
        done = 1'b1;
        repeat (3) cyc();
        ack = 1'b0;
        done = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("bh_resume_addr", 32'(addr[0]), 17);
        chk("bh_resume_req", 32'(req[0]), 1);
        run_instr(0, 0, 1'b0, 0, 1'b0);

        // wrap at 31 (out of range for the 20-word instance)
        run_instr(0, 0, 1'b1, 31, 1'b0);
        chk("wrap_pre", 32'(pcv[0]), 31);
        run_instr(0, 0, 1'b0, 0, 1'b0);
        chk("wrap_pc", 32'(pcv[0]), 0);
        chk("wrap_err", 32'(err[0]), 0);

        // out-of-range target 25 on PROG_SIZE=20
        run_instr(0, 0, 1'b1, 25, 1'b0);
        chk("oor_pc", 32'(pcv[1]), 0);
        chk("oor_err", 32'(err[1]), 1);
        chk("oor_pc32", 32'(pcv[0]), 25);
        repeat (10) run_instr(0, 0, 1'b0, 0, 1'b0);
        chk("oor_sticky", 32'(err[1]), 1);

        // async reset mid-EXEC at pc 9
        run_instr(0, 0, 1'b1, 9, 1'b0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ar_exec_before", 32'(exe[0]), 1);
        chk("ar_pc_before", 32'(pcv[0]), 9);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("ar_exec_en", 32'(exe[0]), 0);
        chk("ar_pc", 32'(pcv[0]), 0);
        chk("ar_req", 32'(req[0]), 0);
        chk("ar_err", 32'(err[1]), 0);
        model_reset();
        done = 1'b1;
        cyc();
        done = 1'b0;
        sys_rst_n = 1'b1;
        repeat (3) cyc();
        chk("ar_idle_pc", 32'(pcv[0]), 0);

        // randomized traffic, inputs also toggled outside their states
        repeat (800) begin
            start = ($urandom_range(0, 9) < 3);
            ack   = ($urandom_range(0, 1) == 1);
            done  = ($urandom_range(0, 9) < 4);
            taken = ($urandom_range(0, 9) < 3);
            tgt   = 5'($urandom);
            halt  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                sys_rst_n = 1'b0;
                model_reset();
            end else begin
                sys_rst_n = 1'b1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
